// File: rtl/a2d_conv_sched.sv
// a2d_conv_sched: periodic A2D conversion scheduler for the analog front end.
// Triggers one conversion every 2^PERIOD_W clocks, runs the two-frame SPI
// protocol (channel command, then read) and keeps the latest 12-bit result
// per channel. Owns the SPI master snd/done handshake.
// Build macros:
//   A2D_CURR_PRIORITY_EN - 6-slot sequence CURR,BATT,CURR,BRAKE,CURR,TORQUE
//                          (default: plain 4-slot round robin)
//   FAST_SIM             - shortens the default trigger period to 2^8 clocks
module a2d_conv_sched #(
`ifdef FAST_SIM
    parameter int         PERIOD_W  = 8,
`else
    parameter int         PERIOD_W  = 14,
`endif
    parameter logic [2:0] CH_BATT   = 3'd0,
    parameter logic [2:0] CH_CURR   = 3'd1,
    parameter logic [2:0] CH_BRAKE  = 3'd3,
    parameter logic [2:0] CH_TORQUE = 3'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        snd,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] resp,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic        cnv_cmplt,
    output logic [1:0]  ch_upd,
    output logic        ovr
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_WAIT_CMD = 3'd2,
        ST_GAP      = 3'd3,
        ST_READ     = 3'd4,
        ST_WAIT_RD  = 3'd5,
        ST_UPD      = 3'd6
    } state_t;

`ifdef A2D_CURR_PRIORITY_EN
    localparam int               PTR_W    = 3;
    localparam logic [PTR_W-1:0] PTR_LAST = 3'd5;
`else
    localparam int               PTR_W    = 2;
    localparam logic [PTR_W-1:0] PTR_LAST = 2'd3;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [PERIOD_W-1:0] r_timer;
    logic                w_trig;
    logic [PTR_W-1:0]    r_ptr;
    logic [1:0]          w_idx;
    logic [2:0]          w_chnl;
    logic                r_snd;
    logic [15:0]         r_cmd;
    logic [11:0]         r_batt;
    logic [11:0]         r_curr;
    logic [11:0]         r_brake;
    logic [11:0]         r_torque;
    logic                r_cnv_cmplt;
    logic [1:0]          r_ch_upd;
    logic                r_ovr;
    logic                w_unused_resp;

    // Only the low 12 bits of the read frame carry the conversion result.
    assign w_unused_resp = ^resp[15:12];

    // One trigger per timer wrap, on the all-ones count.
    assign w_trig = &r_timer;

    // Free-running trigger timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= {PERIOD_W{1'b0}};
        end else begin
            r_timer <= r_timer + {{(PERIOD_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef A2D_CURR_PRIORITY_EN
    // Map the 6-slot sequence position to the result-register index.
    always_comb begin
        w_idx = 2'd1;
        case (r_ptr)
            3'd0:    w_idx = 2'd1;
            3'd1:    w_idx = 2'd0;
            3'd2:    w_idx = 2'd1;
            3'd3:    w_idx = 2'd2;
            3'd4:    w_idx = 2'd1;
            3'd5:    w_idx = 2'd3;
            default: w_idx = 2'd1;
        endcase
    end
`else
    // Plain round robin: the slot number is the result-register index.
    always_comb begin
        w_idx = r_ptr;
    end
`endif

    // Translate result-register index to the converter's channel number.
    always_comb begin
        w_chnl = CH_BATT;
        case (w_idx)
            2'd0:    w_chnl = CH_BATT;
            2'd1:    w_chnl = CH_CURR;
            2'd2:    w_chnl = CH_BRAKE;
            2'd3:    w_chnl = CH_TORQUE;
            default: w_chnl = CH_BATT;
        endcase
    end

    // Conversion sequencer next-state logic; done outside the wait states is ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_next = ST_CMD;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_CMD:      w_next = ST_WAIT_CMD;
            ST_WAIT_CMD: begin
                if (done) begin
                    w_next = ST_GAP;
                end else begin
                    w_next = ST_WAIT_CMD;
                end
            end
            ST_GAP:      w_next = ST_READ;
            ST_READ:     w_next = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (done) begin
                    w_next = ST_UPD;
                end else begin
                    w_next = ST_WAIT_RD;
                end
            end
            ST_UPD:      w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // SPI request outputs, registered so snd/cmd are high exactly in CMD/READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snd <= 1'b0;
            r_cmd <= 16'h0000;
        end else begin
            r_snd <= (w_next == ST_CMD) || (w_next == ST_READ);
            if (w_next == ST_CMD) begin
                r_cmd <= {2'b00, w_chnl, 11'h000};
            end else begin
                r_cmd <= r_cmd;
            end
        end
    end

    // Capture the read-frame result into the selected channel register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_batt   <= 12'h000;
            r_curr   <= 12'h000;
            r_brake  <= 12'h000;
            r_torque <= 12'h000;
        end else if ((r_state == ST_WAIT_RD) && done) begin
            case (w_idx)
                2'd0:    r_batt   <= resp[11:0];
                2'd1:    r_curr   <= resp[11:0];
                2'd2:    r_brake  <= resp[11:0];
                2'd3:    r_torque <= resp[11:0];
                default: r_batt   <= r_batt;
            endcase
        end else begin
            r_batt   <= r_batt;
            r_curr   <= r_curr;
            r_brake  <= r_brake;
            r_torque <= r_torque;
        end
    end

    // Completion pulse and updated-channel index, high during UPD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnv_cmplt <= 1'b0;
            r_ch_upd    <= 2'd0;
        end else begin
            r_cnv_cmplt <= (w_next == ST_UPD);
            if (w_next == ST_UPD) begin
                r_ch_upd <= w_idx;
            end else begin
                r_ch_upd <= r_ch_upd;
            end
        end
    end

    // Sequence pointer advances once per completed conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= {PTR_W{1'b0}};
        end else if (r_state == ST_UPD) begin
            if (r_ptr == PTR_LAST) begin
                r_ptr <= {PTR_W{1'b0}};
            end else begin
                r_ptr <= r_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Sticky overrun: a trigger that finds the sequencer busy is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (w_trig && (r_state != ST_IDLE)) begin
            r_ovr <= 1'b1;
        end else begin
            r_ovr <= r_ovr;
        end
    end

    assign snd       = r_snd;
    assign cmd       = r_cmd;
    assign batt      = r_batt;
    assign curr      = r_curr;
    assign brake     = r_brake;
    assign torque    = r_torque;
    assign cnv_cmplt = r_cnv_cmplt;
    assign ch_upd    = r_ch_upd;
    assign ovr       = r_ovr;

endmodule

// File: doc/a2d_conv_sched.md
Name: a2d_conv_sched

Overview:
- Conversion scheduler for the analog front end (battery, motor current, brake, torque).
- Sits between sensor conditioning and the shared SPI master that talks to the A2D converter.
- Periodically triggers conversions, round-robins channels, runs the two-transaction SPI protocol per conversion, and holds the latest 12-bit result per channel.
- Sole owner of the SPI master handshake.

Parameters:
- PERIOD_W, 14: width of free-running trigger timer; one conversion starts every 2^PERIOD_W clocks (FAST_SIM builds use 8).
- CH_BATT, 3'd0: A2D channel number for battery.
- CH_CURR, 3'd1: A2D channel number for motor current.
- CH_BRAKE, 3'd3: A2D channel number for brake lever.
- CH_TORQUE, 3'd4: A2D channel number for pedal torque.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- snd  out  1  one-cycle request to SPI master to start a 16-bit transaction
- cmd  out  16  data to shift out; valid while snd high
- done  in  1  one-cycle pulse from SPI master: transaction complete
- resp  in  16  data shifted in; valid when done high
- batt  out  12  latest battery reading
- curr  out  12  latest current reading
- brake  out  12  latest brake reading
- torque  out  12  latest torque reading
- cnv_cmplt  out  1  one-cycle pulse when any channel register updates
- ch_upd  out  2  index of channel just updated (0 batt, 1 curr, 2 brake, 3 torque); valid with cnv_cmplt
- ovr  out  1  sticky: trigger arrived while busy

Behaviour:
- Reset values:
  - all four result registers 12'h000, FSM IDLE, timer 0, round-robin pointer 0 (batt).
  - snd 0, cmd 16'h0000, cnv_cmplt 0, ch_upd 0, ovr 0.
- Timer: PERIOD_W-bit free-running up-counter, wraps to 0; trig = (timer all-ones), one cycle per wrap.
- FSM states: IDLE, CMD, WAIT_CMD, GAP, READ, WAIT_RD, UPD.
  - IDLE: on trig -> CMD.
  - CMD: snd=1 for exactly one cycle; cmd = {2'b00, chnl[2:0], 11'h000}. -> WAIT_CMD.
  - WAIT_CMD: hold until done; resp discarded. -> GAP.
  - GAP: one idle cycle, SPI master needs SS_n high between frames. -> READ.
  - READ: snd=1 for one cycle; cmd unchanged. -> WAIT_RD.
  - WAIT_RD: on done, capture resp[11:0] into the pointed channel register that same edge. -> UPD.
  - UPD: cnv_cmplt=1 and ch_upd=pointer for one cycle; pointer advances mod 4. -> IDLE.
- Latency: trig to cnv_cmplt = 2 SPI transactions + 5 clocks.
- Results update only in WAIT_RD on done. Other registers hold; outputs are always registers, never combinational from resp.
- done seen in IDLE/CMD/GAP/READ/UPD is ignored, with no state change.
- trig while not IDLE: conversion not queued; ovr set, stays set until reset.
- trig and return to IDLE on the same cycle: trig is not serviced, ovr is set.
- snd never asserted on two consecutive cycles. cmd stable from the snd cycle until the following done.
- Reset mid-transaction: FSM to IDLE immediately; partial result discarded, registers cleared. The SPI master is reset by the same rst_n.

Optional Feature:
- Macro: A2D_CURR_PRIORITY_EN.
- Defined: 6-slot sequence CURR, BATT, CURR, BRAKE, CURR, TORQUE, so current is sampled every second conversion for the PI loop.
  - Pointer is a 3-bit slot counter wrapping 5->0.
  - ch_upd reports the actual channel.
- Undefined: plain 4-slot round robin BATT, CURR, BRAKE, TORQUE.

Test Plan:
- Reset, then model SPI master with done 32 clocks after each snd.
  - Expected cmd sequence: 16'h0000, 16'h0000, 16'h0800, 16'h0800, 16'h1800, 16'h1800, 16'h2000, 16'h2000.
  - cnv_cmplt pulses 4 times with ch_upd 0, 1, 2, 3.
- SPI model returns resp 16'hFB11 on read frames, 16'hFFFF on command frames.
  - batt = 12'hB11 after first cnv_cmplt; curr, brake, torque still 0.
- Hold done off for 2^PERIOD_W + 10 clocks.
  - ovr = 1; FSM stays in WAIT_CMD with snd 0.
  - Release done: sequence completes normally, ovr stays 1.
- Assert rst_n low during WAIT_RD.
  - All outputs return to reset values within 0 clocks (asynchronous).
  - First trig after release issues cmd 16'h0000 (batt).
- Pulse done in IDLE and in GAP: no state change, no register update, no cnv_cmplt.
- With A2D_CURR_PRIORITY_EN, 6 conversions: ch_upd sequence 1, 0, 1, 2, 1, 3, then repeats from 1.
